// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo counter family and its prescaler.
//   DIR_UP / DIR_DOWN : encodings of the `up` direction input.
//   clog2_min1()      : ceil(log2(value)) clamped to at least 1, used to size
//                       prescaler registers so PRESCALE = 1 still yields a
//                       one-bit register.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Smallest bit count able to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage : counter_pkg

// File: rtl/mod_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides enabled clock cycles by PRESCALE. The internal counter runs
// 0..PRESCALE-1 and advances only while `enable` is high; `tick` is high in
// the cycle the counter sits on its last value with `enable` high, and the
// counter returns to 0 on that edge. `clear` zeroes the counter and masks
// `tick` in the same cycle.
//
// Parameters : PRESCALE  enabled cycles per tick (>= 1)
// Ports      : clock     rising-edge clock
//              reset     asynchronous, active-high reset
//              enable    advance the prescaler
//              clear     synchronous clear, suppresses tick
//              tick      combinational strobe, one per PRESCALE enabled cycles
// -----------------------------------------------------------------------------
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PRE_W = clog2_min1(PRESCALE);
    localparam logic [PRE_W-1:0] LAST_C = PRE_W'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $fatal(1, "tick_prescaler: PRESCALE must be at least 1");
        end
    endgenerate

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_nxt_s;
    logic             at_last_s;

    // Terminal-count detect and tick strobe; clear masks the strobe.
    always_comb begin
        at_last_s = (pre_r == LAST_C);
        tick      = enable & ~clear & at_last_s;
    end

    // Next prescaler value: clear > wrap at terminal count > increment > hold.
    always_comb begin
        pre_nxt_s = pre_r;
        if (clear) begin
            pre_nxt_s = {PRE_W{1'b0}};
        end else if (enable) begin
            if (at_last_s) begin
                pre_nxt_s = {PRE_W{1'b0}};
            end else begin
                pre_nxt_s = pre_r + PRE_W'(1);
            end
        end else begin
            pre_nxt_s = pre_r;
        end
    end

    // Prescaler state register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_r <= {PRE_W{1'b0}};
        end else begin
            pre_r <= pre_nxt_s;
        end
    end

endmodule : tick_prescaler

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo up/down counter with a clock-enable prescaler, synchronous clear,
// optional synchronous load and a registered wrap pulse. Default parameters
// give the free-running 0,1,2,3,0 phase sequence.
//
// Build option: define MOD_COUNTER_LOAD_EN to add the `load`/`load_value`
// ports and load logic. Without it the ports do not exist and the edge
// priority is reset > clear > step.
//
// Parameters : WIDTH       count width in bits
//              MODULO      sequence length, 2 <= MODULO <= 2**WIDTH
//              PRESCALE    enabled cycles per count step, >= 1
// Ports      : clock       rising-edge clock
//              reset       asynchronous, active-high reset
//              enable      advance the prescaler; low holds all state
//              clear       synchronous clear of count and prescaler
//              up          direction, 1 = up, 0 = down (sampled on steps)
//              load        synchronous load (MOD_COUNTER_LOAD_EN only)
//              load_value  value to load, saturated to MODULO-1
//              count       registered count, 0..MODULO-1
//              step        combinational strobe, high when a step is taken
//              wrap        registered pulse, high the cycle after a wrap step
// -----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MODULO   = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             up,
`ifdef MOD_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             wrap
);

    // Terminal value and modulus; the modulus is held at WIDTH+1 bits so
    // MODULO = 2**WIDTH is representable and needs no special case.
    localparam logic [WIDTH-1:0] MAX_C        = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MODULO_EXT_C = (WIDTH + 1)'(MODULO);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "mod_counter: WIDTH must be at least 1");
        end
        if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
            $fatal(1, "mod_counter: MODULO must lie in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $fatal(1, "mod_counter: PRESCALE must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic             step_s;
    logic             pre_clear_s;
    logic [WIDTH:0]   up_sum_s;
    logic             up_wraps_s;
    logic             down_wraps_s;

`ifdef MOD_COUNTER_LOAD_EN
    logic [WIDTH-1:0] load_sat_s;

    // Saturate out-of-range load values to the top of the legal range.
    always_comb begin
        if ({1'b0, load_value} >= MODULO_EXT_C) begin
            load_sat_s = MAX_C;
        end else begin
            load_sat_s = load_value;
        end
    end

    // A load restarts the prescale interval just like a clear does.
    always_comb begin
        pre_clear_s = clear | load;
    end
`else
    // Only clear restarts the prescale interval in this build.
    always_comb begin
        pre_clear_s = clear;
    end
`endif

    // Step timing; the prescaler also masks the step while clear/load is high.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (pre_clear_s),
        .tick   (step_s)
    );

    // Wrap detection for both directions, widened for the up case.
    always_comb begin
        up_sum_s     = {1'b0, count_r} + (WIDTH + 1)'(1);
        up_wraps_s   = (up_sum_s == MODULO_EXT_C);
        down_wraps_s = (count_r == {WIDTH{1'b0}});
    end

    // Next count and wrap: clear > load > step > hold; wrap defaults low.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (clear) begin
            count_nxt_s = {WIDTH{1'b0}};
`ifdef MOD_COUNTER_LOAD_EN
        end else if (load) begin
            count_nxt_s = load_sat_s;
`endif
        end else if (step_s) begin
            if (up == DIR_UP) begin
                if (up_wraps_s) begin
                    count_nxt_s = {WIDTH{1'b0}};
                    wrap_nxt_s  = 1'b1;
                end else begin
                    count_nxt_s = up_sum_s[WIDTH-1:0];
                end
            end else begin
                if (down_wraps_s) begin
                    count_nxt_s = MAX_C;
                    wrap_nxt_s  = 1'b1;
                end else begin
                    count_nxt_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and wrap registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    // Output drive.
    always_comb begin
        count = count_r;
        wrap  = wrap_r;
        step  = step_s;
    end

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Directed, table-driven bench for mod_counter. Several instances cover the
// default configuration, a down-counting prescaled configuration, a PRESCALE 4
// enable-gap/async-reset configuration and, when MOD_COUNTER_LOAD_EN is
// defined, the load path.
// -----------------------------------------------------------------------------
module tb_mod_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---- u0: defaults (WIDTH 2, MODULO 4, PRESCALE 1) ----
    logic       rst0 = 1'b1, en0 = 1'b0, clr0 = 1'b0, up0 = 1'b1;
    logic [1:0] cnt0;
    logic       stp0, wrp0;
`ifdef MOD_COUNTER_LOAD_EN
    logic       ld0 = 1'b0;
    logic [1:0] ldv0 = 2'd0;
`endif
    mod_counter u0 (
        .clock(clock), .reset(rst0), .enable(en0), .clear(clr0), .up(up0),
`ifdef MOD_COUNTER_LOAD_EN
        .load(ld0), .load_value(ldv0),
`endif
        .count(cnt0), .step(stp0), .wrap(wrp0));

    // ---- u1: WIDTH 3, MODULO 5, PRESCALE 3, counting down ----
    logic       rst1 = 1'b1, en1 = 1'b0, clr1 = 1'b0, up1 = 1'b0;
    logic [2:0] cnt1;
    logic       stp1, wrp1;
`ifdef MOD_COUNTER_LOAD_EN
    logic       ld1 = 1'b0;
    logic [2:0] ldv1 = 3'd0;
`endif
    mod_counter #(.WIDTH(3), .MODULO(5), .PRESCALE(3)) u1 (
        .clock(clock), .reset(rst1), .enable(en1), .clear(clr1), .up(up1),
`ifdef MOD_COUNTER_LOAD_EN
        .load(ld1), .load_value(ldv1),
`endif
        .count(cnt1), .step(stp1), .wrap(wrp1));

    // ---- u2: WIDTH 2, MODULO 4, PRESCALE 4 ----
    logic       rst2 = 1'b1, en2 = 1'b0, clr2 = 1'b0, up2 = 1'b1;
    logic [1:0] cnt2;
    logic       stp2, wrp2;
`ifdef MOD_COUNTER_LOAD_EN
    logic       ld2 = 1'b0;
    logic [1:0] ldv2 = 2'd0;
`endif
    mod_counter #(.WIDTH(2), .MODULO(4), .PRESCALE(4)) u2 (
        .clock(clock), .reset(rst2), .enable(en2), .clear(clr2), .up(up2),
`ifdef MOD_COUNTER_LOAD_EN
        .load(ld2), .load_value(ldv2),
`endif
        .count(cnt2), .step(stp2), .wrap(wrp2));

`ifdef MOD_COUNTER_LOAD_EN
    // ---- u3: WIDTH 3, MODULO 5, PRESCALE 1, load path ----
    logic       rst3 = 1'b1, en3 = 1'b0, clr3 = 1'b0, up3 = 1'b1;
    logic       ld3 = 1'b0;
    logic [2:0] ldv3 = 3'd0;
    logic [2:0] cnt3;
    logic       stp3, wrp3;
    mod_counter #(.WIDTH(3), .MODULO(5), .PRESCALE(1)) u3 (
        .clock(clock), .reset(rst3), .enable(en3), .clear(clr3), .up(up3),
        .load(ld3), .load_value(ldv3),
        .count(cnt3), .step(stp3), .wrap(wrp3));
`endif

    // One vector: inputs for a cycle, step expected before the edge,
    // count/wrap expected after it.
    typedef struct {
        logic       en;
        logic       clr;
        logic       up;
        logic       exp_step;
        logic [1:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [12];

    // Advance to just after the next rising edge.
    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // en  clr  up   step count wrap
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
        // clear exactly when an up step from MODULO-1 would wrap
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};

        // Reset phase.
        repeat (2) @(posedge clock);
        #1;
        check("u0_reset_count", int'(cnt0), 0);
        check("u0_reset_wrap",  int'(wrp0), 0);
        check("u1_reset_count", int'(cnt1), 0);
        check("u2_reset_count", int'(cnt2), 0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
`ifdef MOD_COUNTER_LOAD_EN
        rst3 = 1'b0;
`endif
        check("u0_idle_step", int'(stp0), 0);
        next_edge();
        check("u0_idle_count", int'(cnt0), 0);

        // u0 vector table.
        for (int i = 0; i < 12; i++) begin
            en0 = vecs[i].en; clr0 = vecs[i].clr; up0 = vecs[i].up;
            #1;
            check($sformatf("u0_v%0d_step", i), int'(stp0), int'(vecs[i].exp_step));
            next_edge();
            check($sformatf("u0_v%0d_count", i), int'(cnt0), int'(vecs[i].exp_count));
            check($sformatf("u0_v%0d_wrap", i), int'(wrp0), int'(vecs[i].exp_wrap));
        end
        en0 = 1'b0; clr0 = 1'b0;

        // u1: down, PRESCALE 3 -> 0,0,4(wrap),4,4,3.
        begin
            int exp_cnt [6] = '{0, 0, 4, 4, 4, 3};
            int exp_wrp [6] = '{0, 0, 1, 0, 0, 0};
            int exp_stp [6] = '{0, 0, 1, 0, 0, 1};
            en1 = 1'b1;
            for (int k = 0; k < 6; k++) begin
                #1;
                check($sformatf("u1_e%0d_step", k + 1), int'(stp1), exp_stp[k]);
                next_edge();
                check($sformatf("u1_e%0d_count", k + 1), int'(cnt1), exp_cnt[k]);
                check($sformatf("u1_e%0d_wrap", k + 1), int'(wrp1), exp_wrp[k]);
            end
            en1 = 1'b0;
        end

        // u2: enable 2 high, 5 low, 2 high -> one step on 4th enabled edge.
        begin
            logic en_pat [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            int   exp_cnt [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
            int   exp_stp [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
            for (int k = 0; k < 9; k++) begin
                en2 = en_pat[k];
                #1;
                check($sformatf("u2_gap%0d_step", k), int'(stp2), exp_stp[k]);
                next_edge();
                check($sformatf("u2_gap%0d_count", k), int'(cnt2), exp_cnt[k]);
            end
        end
        // Four more enabled edges -> count 2, then two more (mid-interval).
        en2 = 1'b1;
        repeat (4) next_edge();
        check("u2_second_step_count", int'(cnt2), 2);
        repeat (2) next_edge();
        check("u2_mid_interval_count", int'(cnt2), 2);
        check("u2_mid_interval_pre", int'(u2.u_prescaler.pre_r), 2);
        en2 = 1'b0;
        // Asynchronous reset away from any clock edge.
        #3;
        rst2 = 1'b1;
        #1;
        check("u2_async_count", int'(cnt2), 0);
        check("u2_async_wrap",  int'(wrp2), 0);
        check("u2_async_pre",   int'(u2.u_prescaler.pre_r), 0);
        #1;
        rst2 = 1'b0;
        next_edge();
        // Full prescale interval after reset: 0,0,0,1.
        en2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_edge();
            check($sformatf("u2_restart%0d_count", k + 1), int'(cnt2), (k == 3) ? 1 : 0);
        end
        en2 = 1'b0;

`ifdef MOD_COUNTER_LOAD_EN
        // u3: load in range, saturating load, load+clear, load masks step.
        ld3 = 1'b1; ldv3 = 3'd3; en3 = 1'b1;
        #1;
        check("u3_load_step_masked", int'(stp3), 0);
        next_edge();
        check("u3_load3_count", int'(cnt3), 3);
        ldv3 = 3'd7;
        next_edge();
        check("u3_load7_count", int'(cnt3), 4);
        check("u3_load7_wrap", int'(wrp3), 0);
        clr3 = 1'b1; ldv3 = 3'd2;
        next_edge();
        check("u3_load_clear_count", int'(cnt3), 0);
        clr3 = 1'b0; ld3 = 1'b0;
        next_edge();
        check("u3_after_load_count", int'(cnt3), 1);
        en3 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter with clock-enable prescaler, synchronous clear/load and a registered wrap pulse. It generalises the free-running 2-bit phase counter that sequences the traffic-light phases. Default parameters reproduce the 0→1→2→3→0 sequence; wider settings drive longer phase tables and per-phase dwell timers.

## Interface
- `WIDTH`, 2: count width in bits.
- `MODULO`, 4: sequence length; legal range 2 ≤ MODULO ≤ 2^WIDTH. Count range is 0..MODULO-1.
- `PRESCALE`, 1: enabled clock cycles per count step; legal range ≥ 1.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: advance the prescaler; when low, all state holds.
- `clear` in 1: synchronous clear of count and prescaler.
- `up` in 1: direction; 1 counts up, 0 counts down.
- `load` in 1: synchronous load (only with `MOD_COUNTER_LOAD_EN`).
- `load_value` in WIDTH: value to load (only with `MOD_COUNTER_LOAD_EN`).
- `count` out WIDTH: current count, registered.
- `step` out 1: combinational strobe, high in the cycle a count step is taken.
- `wrap` out 1: registered one-cycle pulse, high in the cycle after a wrapping step.

## Operation
- Reset values: `count` = 0, prescaler = 0, `wrap` = 0.
- Per-edge priority: `reset` > `clear` > `load` > step > hold.
- Prescaler:
  - Internal counter `pre` runs 0..PRESCALE-1 and increments only when `enable` = 1.
  - `step` = `enable` && (`pre` == PRESCALE-1). When `step` is high, `pre` returns to 0.
  - With PRESCALE = 1, `step` = `enable`.
- Count on `step`:
  - Up: `count` + 1; MODULO-1 wraps to 0.
  - Down: `count` - 1; 0 wraps to MODULO-1.
  - A wrapping step sets `wrap` = 1 on the same edge; otherwise `wrap` = 0 every cycle.
- `clear`: `count` ← 0, `pre` ← 0, `wrap` ← 0. `step` is suppressed while `clear` is high.
- `load`: `count` ← `load_value`, `pre` ← 0, `wrap` ← 0, and `step` is suppressed.
  - If `load_value` ≥ MODULO, `count` ← MODULO-1 (saturate; never leave the legal range).
- `up` is sampled only on step edges. Changing direction mid-prescale does not reset `pre`.
- Arithmetic is computed at WIDTH+1 bits internally, so the MODULO = 2^WIDTH case needs no special handling.

## Timing
- Latency from `enable` asserting to the first count change: PRESCALE cycles (first step at the PRESCALE-th enabled edge).
- Period per count with `enable` held high: PRESCALE cycles. One full wrap takes MODULO×PRESCALE cycles.
- `wrap` is visible in the same cycle that `count` shows the wrapped value (0 for up, MODULO-1 for down).
- Deasserting `enable` freezes `pre` and `count` mid-interval; re-enabling resumes without loss.
- Asserting `reset` mid-interval takes effect immediately and asynchronously. Deasserting it restarts the sequence from 0 with a full prescale interval.

## Configuration
- `MOD_COUNTER_LOAD_EN` defined: the `load`/`load_value` ports exist, with the behaviour above.
- Not defined: these ports are absent, load logic is not synthesised, and priority reduces to `reset` > `clear` > step.

## Structure
- Shared package `counter_pkg` holds:
  - the direction constants `DIR_UP` = 1 and `DIR_DOWN` = 0;
  - a function `clog2_min1` used for sizing `pre`, returning at least 1 so that PRESCALE = 1 still yields a 1-bit register.
- Sub-module `tick_prescaler` (parameter PRESCALE; ports clock, reset, enable, clear, tick) implements `pre`. It is reused by the phase-dwell timers.
- Parameter legality (MODULO, PRESCALE ranges) is checked at elaboration; violations are fatal.

## Test plan
- Defaults (WIDTH 2, MODULO 4, PRESCALE 1), `enable` high, `up` = 1 → `count` goes 0,1,2,3,0. `wrap` is high only on the cycle `count` = 0 after 3.
- WIDTH 3, MODULO 5, PRESCALE 3, `up` = 0 → after reset, `count` goes 0 to 4 at the 3rd enabled edge with `wrap` = 1, then 3 at the 6th edge.
- PRESCALE 4: `enable` high for 2 cycles, low for 5, high for 2 → exactly one step, on the 4th enabled edge. `count` holds throughout the low period.
- Load enabled, MODULO 5: `load_value` = 3 → `count` = 3. `load_value` = 7 → `count` = 4. `load` and `clear` in the same cycle → `count` = 0.
- `clear` on the edge where `step` would fire from `count` = MODULO-1 → `count` = 0, `wrap` = 0, no step.
- Assert `reset` asynchronously mid-interval with `count` = 2 → `count`, `pre` and `wrap` read 0 before the next clock edge.
